// File: rtl/cpu_pkg.sv
// Shared definitions for the RV64 pipeline: widths, reset/bubble values
// and the fetch-stage state encoding.
package cpu_pkg;

    localparam int          PC_WIDTH    = 64;
    localparam int          INSTR_WIDTH = 32;
    localparam logic [63:0] RESET_PC    = 64'h0000_0000_0000_0000;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_WAIT  = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with flush/load/hold/bubble control.
// A bubble clears valid and inserts NOP; the PC field keeps its last value.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter int                 PC_W    = 64,
    parameter int                 INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(cpu_pkg::NOP_INSTR)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               hold_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               valid_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] instr_o
);

    logic               r_valid;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;

    // Flush beats load, load beats hold, otherwise a bubble is inserted
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= NOP;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_instr <= NOP;
        end else if (load_i) begin
            r_valid <= 1'b1;
            r_pc    <= pc_i;
            r_instr <= instr_i;
        end else if (hold_i) begin
            r_valid <= r_valid;
        end else begin
            r_valid <= 1'b0;
            r_instr <= NOP;
        end
    end

    assign valid_o = r_valid;
    assign pc_o    = r_pc;
    assign instr_o = r_instr;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, single-outstanding imem request FSM, one-entry skid
// buffer for responses that arrive while ID is stalled, and the IF/ID register.
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int                     PC_WIDTH    = cpu_pkg::PC_WIDTH,
    parameter int                     INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = PC_WIDTH'(cpu_pkg::RESET_PC),
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(cpu_pkg::NOP_INSTR)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   ifid_valid_o,
    output logic [PC_WIDTH-1:0]    ifid_pc_o,
    output logic [INSTR_WIDTH-1:0] ifid_instr_o
);

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    fetch_state_e           r_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic                   r_discard;
    logic                   r_buf_valid;
    logic [PC_WIDTH-1:0]    r_buf_pc;
    logic [INSTR_WIDTH-1:0] r_buf_instr;

    logic                   w_ifid_free;
    logic                   w_ifid_load;
    logic [PC_WIDTH-1:0]    w_ifid_pc;
    logic [INSTR_WIDTH-1:0] w_ifid_instr;
    logic [PC_WIDTH-1:0]    w_redirect_pc;
    logic                   w_unused_lsbs;

    assign w_redirect_pc = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
    assign w_unused_lsbs = ^redirect_pc_i[1:0];
    assign w_ifid_free   = ~stall_i | ~ifid_valid_o;

    // Select what (if anything) enters IF/ID this cycle
    always_comb begin
        w_ifid_load  = 1'b0;
        w_ifid_pc    = r_pc;
        w_ifid_instr = imem_rdata_i;
        if (!redirect_i) begin
            case (r_state)
                ST_WAIT: begin
                    if (imem_rvalid_i && !r_discard && w_ifid_free) begin
                        w_ifid_load = 1'b1;
                    end else begin
                        w_ifid_load = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i && r_buf_valid) begin
                        w_ifid_load  = 1'b1;
                        w_ifid_pc    = r_buf_pc;
                        w_ifid_instr = r_buf_instr;
                    end else begin
                        w_ifid_load = 1'b0;
                    end
                end
                default: w_ifid_load = 1'b0;
            endcase
        end else begin
            w_ifid_load = 1'b0;
        end
    end

    // Fetch FSM, PC and skid buffer; redirect overrides everything else
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_FETCH;
            r_pc        <= RESET_PC;
            r_discard   <= 1'b0;
            r_buf_valid <= 1'b0;
            r_buf_pc    <= '0;
            r_buf_instr <= NOP_INSTR;
        end else if (redirect_i) begin
            r_pc        <= w_redirect_pc;
            r_buf_valid <= 1'b0;
            r_buf_instr <= NOP_INSTR;
            case (r_state)
                ST_FETCH: begin
                    r_state   <= ST_WAIT;
                    r_discard <= 1'b1;
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        r_state   <= ST_FETCH;
                        r_discard <= 1'b0;
                    end else begin
                        r_discard <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    r_state   <= ST_FETCH;
                    r_discard <= 1'b0;
                end
                default: begin
                    r_state   <= ST_FETCH;
                    r_discard <= 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                ST_FETCH: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= ST_FETCH;
                        end else if (w_ifid_free) begin
                            r_pc    <= r_pc + PC_STEP;
                            r_state <= ST_FETCH;
                        end else begin
                            r_buf_valid <= 1'b1;
                            r_buf_pc    <= r_pc;
                            r_buf_instr <= imem_rdata_i;
                            r_state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        r_pc        <= r_pc + PC_STEP;
                        r_buf_valid <= 1'b0;
                        r_state     <= ST_FETCH;
                    end
                end
                default: begin
                    r_state   <= ST_FETCH;
                    r_discard <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o  = (r_state == ST_FETCH);
    assign imem_addr_o = r_pc;

    ifid_reg #(
        .PC_W    (PC_WIDTH),
        .INSTR_W (INSTR_WIDTH),
        .NOP     (NOP_INSTR)
    ) u_ifid_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .load_i  (w_ifid_load),
        .hold_i  (stall_i),
        .pc_i    (w_ifid_pc),
        .instr_i (w_ifid_instr),
        .valid_o (ifid_valid_o),
        .pc_o    (ifid_pc_o),
        .instr_o (ifid_instr_o)
    );

endmodule
